// File: rtl/timing_engine_seq_if.sv
// Radio timing engine bus: async enable/RX requests, PLL lock and ramp time in,
// radio front-end controls and owner index out.
interface timing_engine_seq_if #(
    parameter int NUM_CH     = 2,
    parameter int T_ARSTFS_W = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]     enableAsync;
    logic [NUM_CH-1:0]     rxEnAsync;
    logic                  pllSettled;
    logic [T_ARSTFS_W-1:0] tArstFs;
    logic                  radioEnable;
    logic                  radioRxEn;
    logic                  ready;
    logic [CH_W-1:0]       activeCh;
    logic                  pllTimeout;

    modport master (
        output enableAsync, rxEnAsync, pllSettled, tArstFs,
        input  radioEnable, radioRxEn, ready, activeCh, pllTimeout
    );

    modport slave (
        input  enableAsync, rxEnAsync, pllSettled, tArstFs,
        output radioEnable, radioRxEn, ready, activeCh, pllTimeout
    );
endinterface

// File: rtl/timing_engine_seq.sv
// Multi-channel radio timing engine: synchronise requests, grant one owner, wait for PLL,
// ramp for tArstFs cycles, then hold ACTIVE. PLL timeout/HALT under TIMING_ENGINE_SEQ_PLL_TIMEOUT_EN.
module timing_engine_seq #(
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int T_ARSTFS_W  = 8,
    parameter int PLL_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    timing_engine_seq_if.slave  bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_PLL = 3'd1,
        ST_RAMP     = 3'd2,
`ifdef TIMING_ENGINE_SEQ_PLL_TIMEOUT_EN
        ST_HALT     = 3'd4,
`endif
        ST_ACTIVE   = 3'd3
    } state_e;

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] en_sync_q;
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] rx_sync_q;
    logic [NUM_CH-1:0]     en_s;
    logic [NUM_CH-1:0]     rx_s;
    logic [CH_W-1:0]       lowest_s;
    logic                  owner_en_s;
    state_e                state_q, state_d;
    logic [CH_W-1:0]       owner_q, owner_d;
    logic [T_ARSTFS_W-1:0] cnt_q, cnt_d;
    logic                  radio_en_q, rx_en_q, ready_q;

`ifdef TIMING_ENGINE_SEQ_PLL_TIMEOUT_EN
    localparam int WAIT_W = (PLL_TIMEOUT > 1) ? $clog2(PLL_TIMEOUT) : 1;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
`endif

    // Request synchronisers; stage 0 samples the async pins, the last stage feeds the FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            en_sync_q <= '0;
            rx_sync_q <= '0;
        end else begin
            en_sync_q <= {en_sync_q[SYNC_STAGES-2:0], bus.enableAsync};
            rx_sync_q <= {rx_sync_q[SYNC_STAGES-2:0], bus.rxEnAsync};
        end
    end

    assign en_s       = en_sync_q[SYNC_STAGES-1];
    assign rx_s       = rx_sync_q[SYNC_STAGES-1];
    assign owner_en_s = en_s[owner_q];

    // Lowest-index requester wins arbitration
    always_comb begin
        lowest_s = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            lowest_s = en_s[i] ? CH_W'(i) : lowest_s;
        end
    end

    // Next-state logic; losing the owner's enable always returns to IDLE
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
`ifdef TIMING_ENGINE_SEQ_PLL_TIMEOUT_EN
        wait_d    = wait_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
`ifdef TIMING_ENGINE_SEQ_PLL_TIMEOUT_EN
                wait_d = '0;
`endif
                if (|en_s) begin
                    state_d = ST_WAIT_PLL;
                    owner_d = lowest_s;
                end else begin
                    owner_d = '0;
                end
            end
            ST_WAIT_PLL: begin
                if (!owner_en_s) begin
                    state_d = ST_IDLE;
                    owner_d = '0;
                end else if (bus.pllSettled) begin
                    if (bus.tArstFs == '0) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d = ST_RAMP;
                        cnt_d   = bus.tArstFs;
                    end
                end else begin
`ifdef TIMING_ENGINE_SEQ_PLL_TIMEOUT_EN
                    if (wait_q == WAIT_W'(PLL_TIMEOUT - 1)) begin
                        state_d   = ST_HALT;
                        timeout_d = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
`else
                    state_d = ST_WAIT_PLL;
`endif
                end
            end
            ST_RAMP: begin
                if (!owner_en_s) begin
                    state_d = ST_IDLE;
                    owner_d = '0;
                    cnt_d   = '0;
                end else if (cnt_q == T_ARSTFS_W'(1)) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - T_ARSTFS_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (!owner_en_s) begin
                    state_d = ST_IDLE;
                    owner_d = '0;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
`ifdef TIMING_ENGINE_SEQ_PLL_TIMEOUT_EN
            // HALT keeps the owner visible until its request goes away
            ST_HALT: begin
                if (!owner_en_s) begin
                    state_d = ST_IDLE;
                    owner_d = '0;
                end else begin
                    state_d = ST_HALT;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                owner_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State register with outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            cnt_q      <= '0;
            radio_en_q <= 1'b0;
            rx_en_q    <= 1'b0;
            ready_q    <= 1'b0;
`ifdef TIMING_ENGINE_SEQ_PLL_TIMEOUT_EN
            wait_q     <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            radio_en_q <= (state_d == ST_RAMP) || (state_d == ST_ACTIVE);
            rx_en_q    <= (state_d == ST_ACTIVE) && rx_s[owner_d];
            ready_q    <= (state_d == ST_ACTIVE);
`ifdef TIMING_ENGINE_SEQ_PLL_TIMEOUT_EN
            wait_q     <= wait_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign bus.radioEnable = radio_en_q;
    assign bus.radioRxEn   = rx_en_q;
    assign bus.ready       = ready_q;
    assign bus.activeCh    = owner_q;
`ifdef TIMING_ENGINE_SEQ_PLL_TIMEOUT_EN
    assign bus.pllTimeout  = timeout_q;
`else
    assign bus.pllTimeout  = 1'b0;
`endif

endmodule

// File: tb/tb_timing_engine_seq.sv
// Self-checking bench for timing_engine_seq: directed scenarios plus randomised grant/drop
// sequences whose expected output timeline is derived from edge-count arithmetic.
module tb_timing_engine_seq;
    localparam int NUM_CH = 2;
    localparam int SYNC   = 2;
    localparam int TW     = 8;
    localparam int PLL_TO = 10;

    logic clk = 1'b0;
    logic reset;
    int   cmp_cnt = 0;
    int   mis_cnt = 0;
    logic to_sticky = 1'b0;

    timing_engine_seq_if #(.NUM_CH(NUM_CH), .T_ARSTFS_W(TW)) bus ();

    timing_engine_seq #(
        .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .T_ARSTFS_W(TW), .PLL_TIMEOUT(PLL_TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            mis_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic en, input logic rdy, input logic rx,
                           input int ch, input logic to);
        chk({tag, ".radioEnable"}, 32'(bus.radioEnable), 32'(en));
        chk({tag, ".ready"},       32'(bus.ready),       32'(rdy));
        chk({tag, ".radioRxEn"},   32'(bus.radioRxEn),   32'(rx));
        chk({tag, ".activeCh"},    32'(bus.activeCh),    32'(ch));
        chk({tag, ".pllTimeout"},  32'(bus.pllTimeout),  32'(to));
    endtask

    // Inputs change at tick 0; pllSettled rises after tick pll_c (0 = already high);
    // all enables drop after tick drop_c. Expected outputs follow from edge arithmetic.
    task automatic run_grant(input logic [1:0] mask, input int ch, input int ta, input int pll_c,
                             input logic [1:0] rx, input int drop_c, input string tag);
        int t_en;
        int e_drop;
        t_en   = (pll_c + 1 > SYNC + 2) ? pll_c + 1 : SYNC + 2;
        e_drop = drop_c + SYNC + 1;
        bus.tArstFs     = TW'(ta);
        bus.pllSettled  = (pll_c == 0);
        bus.rxEnAsync   = rx;
        bus.enableAsync = mask;
        for (int k = 1; k <= e_drop + 2; k++) begin
            tick();
            chk_out(tag,
                    (k >= t_en) && (k < e_drop),
                    (k >= t_en + ta) && (k < e_drop),
                    (k >= t_en + ta) && (k < e_drop) && rx[ch],
                    ((k >= SYNC + 1) && (k < e_drop)) ? ch : 0,
                    to_sticky);
            if (k == pll_c) bus.pllSettled = 1'b1;
            if (k == drop_c) bus.enableAsync = '0;
        end
    endtask

    initial begin
        logic [1:0] mask;
        logic       old_rx;
        logic       new_rx;
        int         ch;
        int         ta;
        int         pll_c;
        int         t_end;

        reset           = 1'b1;
        bus.enableAsync = '0;
        bus.rxEnAsync   = '0;
        bus.pllSettled  = 1'b0;
        bus.tArstFs     = '0;
        repeat (3) tick();
        chk_out("reset", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        reset = 1'b0;
        tick();
        chk_out("post_reset", 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // ch1 alone, tArstFs=4: radioEnable at SYNC+2 edges, ready 4 later
        run_grant(2'b10, 1, 4, 0, 2'b00, 12, "ch1_ta4");
        // tArstFs=0: radioEnable and ready on the same edge
        run_grant(2'b01, 0, 0, 0, 2'b01, 8, "ta0");
        // Drop while the ramp counter reads 2: ready never asserts
        run_grant(2'b01, 0, 6, 0, 2'b00, 6, "ramp_drop");
        // Late PLL lock
        run_grant(2'b10, 1, 2, 7, 2'b10, 14, "late_pll");

        for (int r = 0; r < 24; r++) begin
            ch    = $urandom_range(0, 1);
            mask  = (ch == 0) ? (($urandom_range(0, 1) == 1) ? 2'b11 : 2'b01) : 2'b10;
            ta    = $urandom_range(0, 6);
            pll_c = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, SYNC + 4);
            t_end = ((pll_c + 1 > SYNC + 2) ? pll_c + 1 : SYNC + 2) + ta + 4;
            run_grant(mask, ch, ta, pll_c, 2'($urandom_range(0, 3)),
                      $urandom_range(1, t_end), "random");
        end

`ifdef TIMING_ENGINE_SEQ_PLL_TIMEOUT_EN
        bus.pllSettled  = 1'b0;
        bus.tArstFs     = TW'(3);
        bus.rxEnAsync   = '0;
        bus.enableAsync = 2'b10;
        for (int k = 1; k <= SYNC + 16; k++) begin
            tick();
            if (k == SYNC + 1 + PLL_TO) to_sticky = 1'b1;
            chk_out("halt", 1'b0, 1'b0, 1'b0, (k >= SYNC + 1) ? 1 : 0, to_sticky);
        end
        bus.enableAsync = '0;
        for (int k = 1; k <= SYNC + 2; k++) begin
            tick();
            chk_out("halt_exit", 1'b0, 1'b0, 1'b0, (k >= SYNC + 1) ? 0 : 1, 1'b1);
        end
        run_grant(2'b10, 1, 3, 0, 2'b10, 10, "after_halt");
`else
        bus.pllSettled  = 1'b0;
        bus.enableAsync = 2'b10;
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk_out("wait_forever", 1'b0, 1'b0, 1'b0, (k >= SYNC + 1) ? 1 : 0, 1'b0);
        end
        bus.tArstFs    = TW'(0);
        bus.pllSettled = 1'b1;
        tick();
        chk_out("wait_late_lock", 1'b1, 1'b1, 1'b0, 1, 1'b0);
        bus.enableAsync = '0;
        repeat (SYNC + 2) tick();
        chk_out("wait_flush", 1'b0, 1'b0, 1'b0, 0, 1'b0);
`endif

        // Both request: ch0 wins; dropping ch0 re-grants ch1 after one IDLE cycle
        bus.tArstFs     = TW'(2);
        bus.pllSettled  = 1'b1;
        bus.rxEnAsync   = '0;
        bus.enableAsync = 2'b11;
        repeat (SYNC + 4) tick();
        chk_out("both_grant0", 1'b1, 1'b1, 1'b0, 0, to_sticky);
        bus.enableAsync = 2'b10;
        repeat (SYNC) tick();
        chk_out("handover_hold", 1'b1, 1'b1, 1'b0, 0, to_sticky);
        tick();
        chk_out("handover_idle", 1'b0, 1'b0, 1'b0, 0, to_sticky);
        tick();
        chk_out("handover_wait", 1'b0, 1'b0, 1'b0, 1, to_sticky);
        tick();
        chk_out("handover_ramp", 1'b1, 1'b0, 1'b0, 1, to_sticky);
        repeat (2) tick();
        chk_out("handover_active", 1'b1, 1'b1, 1'b0, 1, to_sticky);

        // Lower-index request arriving later does not preempt; PLL loss is ignored
        bus.enableAsync = 2'b11;
        bus.pllSettled  = 1'b0;
        repeat (SYNC + 3) tick();
        chk_out("no_preempt", 1'b1, 1'b1, 1'b0, 1, to_sticky);

        // RX follows the owner's request SYNC+1 edges later; the other channel is ignored
        old_rx = 1'b0;
        for (int t = 0; t < 4; t++) begin
            new_rx        = ~old_rx;
            bus.rxEnAsync = {new_rx, 1'($urandom_range(0, 1))};
            for (int k = 1; k <= SYNC + 1; k++) begin
                tick();
                chk_out("rx_follow", 1'b1, 1'b1, (k == SYNC + 1) ? new_rx : old_rx, 1, to_sticky);
            end
            old_rx = new_rx;
        end

        // Reset in ACTIVE clears everything on the next edge
        reset = 1'b1;
        tick();
        to_sticky = 1'b0;
        chk_out("reset_active", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        bus.enableAsync = '0;
        reset = 1'b0;
        repeat (SYNC + 2) tick();
        chk_out("final_idle", 1'b0, 1'b0, 1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
